// File: rtl/pcie_rd_fram_packer.sv
// Packs a pixel stream into RAM-width words and writes them into a
// ping-pong frame buffer. Each half carries a ready flag and a committed
// word count, and the reader hands a half back with a release pulse.
module pcie_rd_fram_packer #(
  parameter int PIX_WIDTH  = 16,
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                    wr_clk_i,
  input  logic                    wr_rst_i,
  input  logic                    frame_start_i,
  input  logic                    pix_valid_i,
  input  logic [PIX_WIDTH-1:0]    pix_data_i,
  input  logic                    pix_last_i,
  output logic                    pix_ready_o,
  output logic                    ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wr_data_o,
  output logic [1:0]              buf_ready_o,
  output logic [2*ADDR_WIDTH-1:0] buf_len_o,
  input  logic [1:0]              buf_release_i,
  output logic                    frame_done_o
);

  localparam int LANES      = DATA_WIDTH / PIX_WIDTH;
  localparam int HALF_WORDS = 2 ** (ADDR_WIDTH - 1);
  localparam int IDX_W      = ADDR_WIDTH - 1;
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMMIT, S_WAIT} state_t;

  state_t                  state_q;
  logic                    cur_half_q;
  logic [IDX_W-1:0]        word_idx_q;
  logic [LANE_W-1:0]       lane_q;
  logic [DATA_WIDTH-1:0]   pack_q;
  logic                    last_q;
  logic                    ram_wr_en_q;
  logic [ADDR_WIDTH-1:0]   ram_wr_addr_q;
  logic [DATA_WIDTH-1:0]   ram_wr_data_q;
  logic [1:0]              buf_ready_q;
  logic [2*ADDR_WIDTH-1:0] buf_len_q;
  logic                    frame_done_q;

  logic [1:0]              buf_ready_d;
  logic [2*ADDR_WIDTH-1:0] buf_len_d;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    accept;
  logic                    word_done;
  logic                    commit;
  logic                    next_half;

  // The only combinational path: a fresh frame sync blocks acceptance at once.
  assign pix_ready_o = (state_q == S_FILL) & ~frame_start_i;
  assign accept      = pix_valid_i & pix_ready_o;
  assign word_done   = (lane_q == LANE_W'(LANES - 1)) | pix_last_i;
  assign next_half   = ~cur_half_q;

  // Drop the incoming pixel into its lane; lanes above it are still zero
  // because the pack register is cleared after every emitted word.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign merged[gi*PIX_WIDTH +: PIX_WIDTH] =
        (lane_q == LANE_W'(gi)) ? pix_data_i : pack_q[gi*PIX_WIDTH +: PIX_WIDTH];
  end

  // Per-half bookkeeping: release clears, a commit sets (and wins on the same bit).
  always_comb begin
    commit      = (state_q == S_COMMIT) & ~frame_start_i;
    buf_ready_d = buf_ready_q & ~buf_release_i;
    buf_len_d   = buf_len_q;
    if (commit) begin
      buf_ready_d[cur_half_q] = 1'b1;
      buf_len_d[cur_half_q*ADDR_WIDTH +: ADDR_WIDTH] =
          ADDR_WIDTH'({1'b0, word_idx_q}) + ADDR_WIDTH'(1);
    end
  end

  // Packing FSM with registered RAM write port and status outputs.
  always_ff @(posedge wr_clk_i or posedge wr_rst_i) begin
    if (wr_rst_i) begin
      state_q       <= S_IDLE;
      cur_half_q    <= 1'b0;
      word_idx_q    <= '0;
      lane_q        <= '0;
      pack_q        <= '0;
      last_q        <= 1'b0;
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
      buf_ready_q   <= '0;
      buf_len_q     <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      ram_wr_en_q  <= 1'b0;
      frame_done_q <= 1'b0;
      buf_ready_q  <= buf_ready_d;
      buf_len_q    <= buf_len_d;
      if (frame_start_i) begin
        // Abandon any partial word and restart at the bottom of half 0.
        lane_q     <= '0;
        word_idx_q <= '0;
        cur_half_q <= 1'b0;
        pack_q     <= '0;
        last_q     <= 1'b0;
        state_q    <= buf_ready_q[0] ? S_WAIT : S_FILL;
      end else begin
        case (state_q)
          S_FILL: begin
            if (accept) begin
              if (word_done) begin
                ram_wr_en_q   <= 1'b1;
                ram_wr_addr_q <= {cur_half_q, word_idx_q};
                ram_wr_data_q <= merged;
                pack_q        <= '0;
                lane_q        <= '0;
                if (pix_last_i || (word_idx_q == IDX_W'(HALF_WORDS - 1))) begin
                  state_q <= S_COMMIT;
                  last_q  <= pix_last_i;
                end else begin
                  word_idx_q <= word_idx_q + IDX_W'(1);
                end
              end else begin
                pack_q <= merged;
                lane_q <= lane_q + LANE_W'(1);
              end
            end
          end
          S_COMMIT: begin
            word_idx_q <= '0;
            if (last_q) begin
              frame_done_q <= 1'b1;
              last_q       <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              cur_half_q <= next_half;
              state_q    <= (!buf_ready_q[next_half] || buf_release_i[next_half])
                            ? S_FILL : S_WAIT;
            end
          end
          S_WAIT: begin
            // Also leave if the half is already free, so a release that
            // arrived together with frame_start cannot strand the writer.
            if (buf_release_i[cur_half_q] || !buf_ready_q[cur_half_q]) begin
              state_q <= S_FILL;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ram_wr_en_o   = ram_wr_en_q;
  assign ram_wr_addr_o = ram_wr_addr_q;
  assign ram_wr_data_o = ram_wr_data_q;
  assign buf_ready_o   = buf_ready_q;
  assign buf_len_o     = buf_len_q;
  assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_pcie_rd_fram_packer.sv
// Randomised bench for the frame buffer packer. A word-level scoreboard
// rebuilds each RAM word from the accepted pixels and tracks per-half
// ready flags and lengths from the commit/release rules.
module tb_pcie_rd_fram_packer;

  localparam int PW    = 16;
  localparam int DW    = 256;
  localparam int AW    = 9;
  localparam int LANES = DW / PW;
  localparam int HALF  = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [PW-1:0] pix_data = '0;
  logic          pix_last = 1'b0;
  logic [1:0]    buf_release = 2'b00;
  logic          pix_ready_o;
  logic          ram_wr_en_o;
  logic [AW-1:0] ram_wr_addr_o;
  logic [DW-1:0] ram_wr_data_o;
  logic [1:0]    buf_ready_o;
  logic [2*AW-1:0] buf_len_o;
  logic          frame_done_o;

  pcie_rd_fram_packer #(.PIX_WIDTH(PW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .wr_clk_i      (clk),
    .wr_rst_i      (rst),
    .frame_start_i (frame_start),
    .pix_valid_i   (pix_valid),
    .pix_data_i    (pix_data),
    .pix_last_i    (pix_last),
    .pix_ready_o   (pix_ready_o),
    .ram_wr_en_o   (ram_wr_en_o),
    .ram_wr_addr_o (ram_wr_addr_o),
    .ram_wr_data_o (ram_wr_data_o),
    .buf_ready_o   (buf_ready_o),
    .buf_len_o     (buf_len_o),
    .buf_release_i (buf_release),
    .frame_done_o  (frame_done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [PW-1:0] cur_px[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  bit            exp_fin[$];
  bit            exp_lst[$];
  int            word_cnt = 0;
  int            acc_frame = 0;
  int            wr_total = 0;
  int            fd_count = 0;
  bit            fd_expect = 1'b0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [DW-1:0] last_wr_data = '0;
  bit            cm_valid = 1'b0;
  logic          cm_half = 1'b0;
  logic [AW-1:0] cm_len = '0;
  logic [1:0]    m_ready = 2'b00;
  logic [AW-1:0] m_len[2] = '{default: '0};

  // Per-cycle scoreboard: check outputs, then absorb this cycle's inputs.
  always @(negedge clk) begin
    logic [DW-1:0] w;
    logic [AW-1:0] a;
    bit fin, lst;
    cm_valid = 1'b0;
    if (rst) begin
      cur_px.delete(); exp_addr.delete(); exp_data.delete();
      exp_fin.delete(); exp_lst.delete();
      word_cnt = 0; acc_frame = 0; fd_expect = 1'b0;
    end else begin
      check_eq("frame_done", DW'(frame_done_o), DW'(fd_expect));
      if (frame_done_o) fd_count++;
      fd_expect = 1'b0;
      check_eq("buf_ready", DW'(buf_ready_o), DW'(m_ready));
      check_eq("buf_len", DW'(buf_len_o), DW'({m_len[1], m_len[0]}));
      if (ram_wr_en_o) begin
        wr_total++;
        last_wr_addr = ram_wr_addr_o;
        last_wr_data = ram_wr_data_o;
        if (exp_addr.size() == 0) begin
          check_eq("spurious_write", DW'(1), DW'(0));
        end else begin
          a = exp_addr.pop_front();
          w = exp_data.pop_front();
          fin = exp_fin.pop_front();
          lst = exp_lst.pop_front();
          check_eq("wr_addr", DW'(ram_wr_addr_o), DW'(a));
          check_eq("wr_data", ram_wr_data_o, w);
          if (fin) begin
            cm_valid = 1'b1;
            cm_half  = a[AW-1];
            cm_len   = AW'(a[AW-2:0]) + AW'(1);
          end
          if (lst) fd_expect = 1'b1;
        end
      end
      if (frame_start) begin
        check_eq("fs_ready_low", DW'(pix_ready_o), DW'(0));
        cur_px.delete();
        word_cnt  = 0;
        acc_frame = 0;
      end else if (pix_valid && pix_ready_o) begin
        acc_frame++;
        cur_px.push_back(pix_data);
        if (cur_px.size() == LANES || pix_last) begin
          w = '0;
          foreach (cur_px[i]) w[i*PW +: PW] = cur_px[i];
          exp_addr.push_back(AW'(word_cnt % (2 * HALF)));
          exp_data.push_back(w);
          exp_fin.push_back(((word_cnt % HALF) == HALF - 1) || pix_last);
          exp_lst.push_back(pix_last);
          word_cnt++;
          cur_px.delete();
        end
      end
    end
  end

  // Half status as seen by the reader: release clears, commit sets and wins.
  always @(posedge clk) begin
    logic [1:0] nxt;
    if (rst) begin
      m_ready = 2'b00;
      m_len[0] = '0;
      m_len[1] = '0;
    end else begin
      nxt = m_ready & ~buf_release;
      if (cm_valid) begin
        nxt[cm_half]  = 1'b1;
        m_len[cm_half] = cm_len;
      end
      m_ready = nxt;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_release(input logic [1:0] r);
    buf_release = r;
    @(posedge clk); #1;
    buf_release = 2'b00;
  endtask

  task automatic start_frame(input bit with_valid);
    frame_start = 1'b1;
    pix_valid   = with_valid;
    pix_data    = 16'hBEEF;
    pix_last    = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
  endtask

  // Pixel value = index within the frame; advances only on acceptance.
  task automatic drive_px(input int n, input bit last_en, input int gap_pct, input int budget);
    int sent = 0;
    int cyc = 0;
    bit acc;
    while (sent < n && cyc < budget) begin
      pix_valid = ($urandom_range(0, 99) >= gap_pct);
      pix_data  = PW'(sent);
      pix_last  = last_en && (sent == n - 1);
      @(negedge clk);
      acc = pix_valid && pix_ready_o;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    check_eq("pixels_sent", DW'(sent), DW'(n));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ready"}, DW'(pix_ready_o), DW'(0));
    check_eq({tag, "_wr_en"}, DW'(ram_wr_en_o), DW'(0));
    check_eq({tag, "_addr"}, DW'(ram_wr_addr_o), DW'(0));
    check_eq({tag, "_data"}, ram_wr_data_o, DW'(0));
    check_eq({tag, "_bufrdy"}, DW'(buf_ready_o), DW'(0));
    check_eq({tag, "_buflen"}, DW'(buf_len_o), DW'(0));
    check_eq({tag, "_fdone"}, DW'(frame_done_o), DW'(0));
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, fd0;
    logic [DW-1:0] expw;

    // Reset state
    #1 rst = 1'b1;
    #2 check_outputs_zero("reset");
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    $display("reset done, outputs checked");

    // 1: full frame fills both halves
    fd0 = fd_count; w0 = wr_total;
    start_frame(1'b0);
    drive_px(8192, 1'b1, 0, 9000);
    wait_cycles(4);
    check_eq("t1_writes", DW'(wr_total - w0), DW'(512));
    check_eq("t1_ready", DW'(buf_ready_o), DW'(2'b11));
    check_eq("t1_len", DW'(buf_len_o), DW'({9'd256, 9'd256}));
    check_eq("t1_frame_done", DW'(fd_count - fd0), DW'(1));
    $display("t1 full frame: writes=%0d ready=%b", wr_total - w0, buf_ready_o);

    // 2: overflow into a busy half, then resume after release
    pulse_release(2'b11);
    w0 = wr_total;
    start_frame(1'b0);
    fork
      drive_px(12288, 1'b1, 0, 20000);
      begin
        int k;
        for (k = 0; k < 10000 && wr_total < w0 + 512; k++) begin
          @(posedge clk); #1;
        end
        check_eq("t2_reach_512", DW'(wr_total - w0), DW'(512));
        wait_cycles(20);
        @(negedge clk);
        check_eq("t2_wait_ready", DW'(pix_ready_o), DW'(0));
        check_eq("t2_accepted", DW'(acc_frame), DW'(8192));
        @(posedge clk); #1;
        pulse_release(2'b01);
        for (k = 0; k < 100 && wr_total <= w0 + 512; k++) begin
          @(posedge clk); #1;
        end
        expw = '0;
        for (int i = 0; i < LANES; i++) expw[i*PW +: PW] = PW'(8192 + i);
        check_eq("t2_resume_addr", DW'(last_wr_addr), DW'(0));
        check_eq("t2_resume_data", last_wr_data, expw);
        $display("t2 resume at addr %0d after release", last_wr_addr);
      end
    join
    wait_cycles(4);
    check_eq("t2_writes", DW'(wr_total - w0), DW'(768));

    // 3: short frame with partial last word
    pulse_release(2'b11);
    start_frame(1'b0);
    drive_px(20, 1'b1, 25, 200);
    wait_cycles(4);
    expw = '0;
    for (int i = 0; i < 4; i++) expw[i*PW +: PW] = PW'(16 + i);
    check_eq("t3_addr1", DW'(last_wr_addr), DW'(1));
    check_eq("t3_data1", last_wr_data, expw);
    check_eq("t3_ready", DW'(buf_ready_o), DW'(2'b01));
    check_eq("t3_len0", DW'(buf_len_o[AW-1:0]), DW'(2));
    $display("t3 short frame: ready=%b len0=%0d", buf_ready_o, buf_len_o[AW-1:0]);

    // 4: abort a partial word, frame_start together with pix_valid
    pulse_release(2'b01);
    start_frame(1'b0);
    drive_px(7, 1'b0, 0, 100);
    w0 = wr_total;
    start_frame(1'b1);
    wait_cycles(3);
    check_eq("t4_no_write", DW'(wr_total - w0), DW'(0));
    drive_px(40, 1'b1, 30, 1000);
    wait_cycles(4);
    check_eq("t4_ready", DW'(buf_ready_o), DW'(2'b01));
    check_eq("t4_len0", DW'(buf_len_o[AW-1:0]), DW'(3));
    $display("t4 abort then frame: writes=%0d", wr_total - w0);

    // 5: release of half 1 in half 0's commit cycle
    pulse_release(2'b01);
    start_frame(1'b0);
    drive_px(4096 + 32, 1'b1, 0, 5000);
    wait_cycles(4);
    check_eq("t5_setup_ready", DW'(buf_ready_o), DW'(2'b11));
    pulse_release(2'b01);
    start_frame(1'b0);
    fork
      drive_px(4096 + 48, 1'b1, 0, 6000);
      begin
        int k;
        for (k = 0; k < 6000; k++) begin
          @(negedge clk);
          if (ram_wr_en_o && ram_wr_addr_o == AW'(255)) break;
        end
        check_eq("t5_commit_seen", DW'(k < 6000), DW'(1));
        #1 buf_release = 2'b10;
        @(negedge clk);
        check_eq("t5_straight_fill", DW'(pix_ready_o), DW'(1));
        #1 buf_release = 2'b00;
      end
    join
    wait_cycles(4);
    check_eq("t5_ready", DW'(buf_ready_o), DW'(2'b11));
    check_eq("t5_len1", DW'(buf_len_o[2*AW-1:AW]), DW'(3));
    pulse_release(2'b01);
    pulse_release(2'b01);
    wait_cycles(2);
    check_eq("t5_clear_release", DW'(buf_ready_o), DW'(2'b10));
    $display("t5 release in commit: ready=%b", buf_ready_o);

    // 6: random gaps, async reset mid-fill
    pulse_release(2'b11);
    start_frame(1'b0);
    drive_px(50, 1'b0, 40, 1000);
    @(negedge clk); #2 rst = 1'b1;
    #1 check_outputs_zero("midrst");
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    pix_valid = 1'b1;
    pix_data  = 16'h1234;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("t6_no_wr", DW'(ram_wr_en_o), DW'(0));
      check_eq("t6_no_ready", DW'(pix_ready_o), DW'(0));
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    start_frame(1'b0);
    drive_px(16, 1'b1, 40, 500);
    wait_cycles(4);
    check_eq("t6_ready", DW'(buf_ready_o), DW'(2'b01));
    check_eq("t6_len0", DW'(buf_len_o[AW-1:0]), DW'(1));
    $display("t6 reset recovery: ready=%b", buf_ready_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
